pipeline_en_flush_sync_rstn: RTL

- Parametrised multi-stage pipeline register with a valid/ready handshake, bubble collapsing, flush and an occupancy count.
- Generalises the single enable/flush register to DEPTH stages.
- Per-stage valid bits replace the global enable, and stages advance independently under backpressure.
- Sits between datapath stages that need elastic buffering and a kill path, for example a fetch or decode pipe that is flushed on redirect.

---
 rtl/pipeline_en_flush_sync_rstn.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pipeline_en_flush_sync_rstn.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_en_flush_sync_rstn
// Purpose  : DEPTH-stage elastic pipeline register with a valid/ready
//            handshake on both sides. Bubbles collapse, so a full pipe
//            sustains one item per cycle. A flush kills every in-flight
//            entry, and an occupancy count reports the number of valid
//            stages.
// Ports    : clk        - clock; all state updates on its rising edge
//            rstn       - synchronous active-low reset
//            flush      - kill all in-flight entries
//            in_valid   - upstream item present
//            in_ready   - pipeline accepts in_data this cycle
//            in_data    - upstream payload [WIDTH-1:0]
//            out_valid  - last stage holds a valid item
//            out_ready  - downstream accepts out_data
//            out_data   - last-stage payload [WIDTH-1:0]
//            occupancy  - popcount of stage valid bits [$clog2(DEPTH+1)-1:0]
// Options  : PIPE_FLUSH_DATA_CLEAR_EN - when defined, a flush also returns
//            every stage data register to RESET_VAL.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_en_flush_sync_rstn #(
   parameter int               WIDTH     = 32,
   parameter int               DEPTH     = 3,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           flush,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [WIDTH-1:0]               in_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [WIDTH-1:0]               out_data,
   output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

   localparam int OCC_W = $clog2(DEPTH + 1);

   // Stage state: index 0 is the input side, DEPTH-1 the output side.
   logic [DEPTH-1:0] v_q;
   logic [DEPTH-1:0] v_d;
   logic [WIDTH-1:0] d_q [DEPTH];
   logic [WIDTH-1:0] d_d [DEPTH];

   logic [DEPTH-1:0] adv;          // stage i hands its item on this cycle
   logic [DEPTH-1:0] ld;           // stage i captures a new item this cycle
   logic             in_ready_raw; // acceptance ignoring flush

   // Advance chain, resolved from the output side back toward the input so
   // that each stage sees the decision of the stage downstream of it.
   always_comb begin
      adv            = '0;
      adv[DEPTH-1]   = v_q[DEPTH-1] & out_ready;
      for (int i = DEPTH - 2; i >= 0; i--) begin
         adv[i] = v_q[i] & (~v_q[i+1] | adv[i+1]);
      end
   end

   assign in_ready_raw = ~v_q[0] | adv[0];

   // A flush cycle completes no handshake on either side.
   assign in_ready  = in_ready_raw & ~flush;
   assign out_valid = v_q[DEPTH-1] & ~flush;
   assign out_data  = flush ? '0 : d_q[DEPTH-1];

   // Loads are masked by flush so no data moves during a flush cycle.
   always_comb begin
      ld    = '0;
      ld[0] = in_valid & in_ready;
      for (int i = 1; i < DEPTH; i++) begin
         ld[i] = adv[i-1] & ~flush;
      end
   end

   always_comb begin
      v_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
         v_d[i] = flush ? 1'b0 : (ld[i] | (v_q[i] & ~adv[i]));
      end
   end

   // Data registers are enable-gated: they only change on a load.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         d_d[i] = d_q[i];
      end
      if (ld[0]) begin
         d_d[0] = in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
         if (ld[i]) begin
            d_d[i] = d_q[i-1];
         end
      end
`ifdef PIPE_FLUSH_DATA_CLEAR_EN
      // Scrub payloads on flush so a killed item can never be observed.
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            d_d[i] = RESET_VAL;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         v_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            d_q[i] <= RESET_VAL;
         end
      end else begin
         v_q <= v_d;
         for (int i = 0; i < DEPTH; i++) begin
            d_q[i] <= d_d[i];
         end
      end
   end

   // Counts registered valid bits only; deliberately not masked by flush.
   always_comb begin
      occupancy = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occupancy = occupancy + OCC_W'(v_q[i]);
      end
   end

endmodule
`default_nettype wire
